// File: rtl/match_log_pkg.sv
// ============================================================================
// Module   : match_log_pkg
// Purpose  : Shared defaults and helpers for the match event logger.
//            Holds the default widths/depth and a saturating increment.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package match_log_pkg;

    localparam int TS_W_DEF  = 16;
    localparam int DEPTH_DEF = 4;
    localparam int CNT_W_DEF = 8;

    // Saturating +1 for a counter of 'width' bits (width <= 32)
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input int width);
        logic [31:0] max_v;
        max_v = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (val >= max_v) ? max_v : (val + 32'd1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/match_log_fifo.sv
// ============================================================================
// Module   : match_log_fifo
// Purpose  : Synchronous DEPTH x W FIFO with push/pop/full/empty and a
//            synchronous clear. Pointers carry one extra wrap bit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module match_log_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] data_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_q, wr_d;
    logic [AW:0]  rd_q, rd_d;
    logic [W-1:0] mem_q [DEPTH];
    logic         do_push;
    logic         do_pop;

    // Full/empty from wrap-bit compare; a pop frees the slot a same-edge push needs
    always_comb begin
        empty_o = (wr_q == rd_q);
        full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
        do_pop  = pop_i && !empty_o;
        do_push = push_i && (!full_o || do_pop);
        wr_d    = clr_i ? '0 : (wr_q + (AW+1)'(do_push));
        rd_d    = clr_i ? '0 : (rd_q + (AW+1)'(do_pop));
        data_o  = empty_o ? '0 : mem_q[rd_q[AW-1:0]];
    end

    // Pointer registers, discarded on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage; contents are only visible between rd and wr so no reset needed
    always_ff @(posedge clk) begin
        if (do_push && !clr_i) begin
            mem_q[wr_q[AW-1:0]] <= data_i;
        end
    end

endmodule

`default_nettype wire

// File: rtl/match_event_logger.sv
// ============================================================================
// Module   : match_event_logger
// Purpose  : Timestamps each detector match, queues timestamps in a FIFO with
//            valid/ready readout, keeps saturating match/drop counts and a
//            sticky overflow flag.
//            Optional macro MATCH_LOG_CLEAR_EN adds a synchronous clr input.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module match_event_logger
    import match_log_pkg::*;
#(
    parameter int TS_W  = TS_W_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             z,
    output logic [TS_W-1:0]  ts_data,
    output logic             ts_valid,
    input  logic             ts_ready,
    output logic [CNT_W-1:0] match_count,
    output logic [CNT_W-1:0] drop_count,
    output logic             overflow
`ifdef MATCH_LOG_CLEAR_EN
    ,
    input  logic             clr
`endif
);

    logic [TS_W-1:0]  ts_ctr_q, ts_ctr_d;
    logic [CNT_W-1:0] match_q, match_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic             ovf_q, ovf_d;
    logic             clear;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic             drop;

`ifdef MATCH_LOG_CLEAR_EN
    assign clear = clr;
`else
    assign clear = 1'b0;
`endif

    match_log_fifo #(
        .DEPTH (DEPTH),
        .W     (TS_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (clear),
        .push_i  (z),
        .pop_i   (pop),
        .data_i  (ts_ctr_q),
        .data_o  (ts_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Drop decision and next-state for timestamp counter, counts and overflow
    always_comb begin
        ts_valid = !fifo_empty;
        pop      = ts_valid && ts_ready;
        drop     = z && fifo_full && !pop;
        ts_ctr_d = ts_ctr_q + 1'b1;
        match_d  = match_q;
        drop_d   = drop_q;
        ovf_d    = ovf_q;
        if (z) begin
            match_d = CNT_W'(sat_inc(32'(match_q), CNT_W));
        end
        if (drop) begin
            drop_d = CNT_W'(sat_inc(32'(drop_q), CNT_W));
            ovf_d  = 1'b1;
        end
        if (clear) begin
            ts_ctr_d = '0;
            match_d  = '0;
            drop_d   = '0;
            ovf_d    = 1'b0;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_ctr_q <= '0;
            match_q  <= '0;
            drop_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            ts_ctr_q <= ts_ctr_d;
            match_q  <= match_d;
            drop_q   <= drop_d;
            ovf_q    <= ovf_d;
        end
    end

    assign match_count = match_q;
    assign drop_count  = drop_q;
    assign overflow    = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_match_event_logger.sv
// ============================================================================
// Module   : tb_match_event_logger
// Purpose  : Directed self-checking bench for match_event_logger. A default
//            instance (TS_W=16, CNT_W=8) and a narrow instance (TS_W=4,
//            CNT_W=2) for wrap and saturation.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_match_event_logger;

    logic        clk;
    logic        rst_n;
    logic        z, ts_ready;
    logic [15:0] ts_data;
    logic        ts_valid;
    logic [7:0]  match_count, drop_count;
    logic        overflow;

    logic        z2, ts_ready2;
    logic [3:0]  ts_data2;
    logic        ts_valid2;
    logic [1:0]  match_count2, drop_count2;
    logic        overflow2;

    logic        clr, clr2;

    int errors = 0;
    int checks = 0;
    int ts     = 0;   // value ts_ctr will present at the next edge
    int a, b, c;

    match_event_logger #(.TS_W(16), .DEPTH(4), .CNT_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .z           (z),
        .ts_data     (ts_data),
        .ts_valid    (ts_valid),
        .ts_ready    (ts_ready),
        .match_count (match_count),
        .drop_count  (drop_count),
        .overflow    (overflow)
`ifdef MATCH_LOG_CLEAR_EN
        ,
        .clr         (clr)
`endif
    );

    match_event_logger #(.TS_W(4), .DEPTH(4), .CNT_W(2)) dut2 (
        .clk         (clk),
        .rst_n       (rst_n),
        .z           (z2),
        .ts_data     (ts_data2),
        .ts_valid    (ts_valid2),
        .ts_ready    (ts_ready2),
        .match_count (match_count2),
        .drop_count  (drop_count2),
        .overflow    (overflow2)
`ifdef MATCH_LOG_CLEAR_EN
        ,
        .clr         (clr2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        ts++;
        #1;
    endtask

    initial begin
        rst_n = 1'b0; z = 1'b0; ts_ready = 1'b0; z2 = 1'b0; ts_ready2 = 1'b0;
        clr = 1'b0; clr2 = 1'b0;

        // Reset held three cycles
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(ts_valid), 0);
        check("rst_data", 32'(ts_data), 0);
        check("rst_match", 32'(match_count), 0);
        check("rst_drop", 32'(drop_count), 0);
        check("rst_ovf", 32'(overflow), 0);
        check("rst_valid2", 32'(ts_valid2), 0);
        rst_n = 1'b1;
        ts = 0;

        // First edge after release samples ts_ctr=0
        z = 1'b1; tick(); z = 1'b0;
        check("first_valid", 32'(ts_valid), 1);
        check("first_data", 32'(ts_data), 0);
        check("first_match", 32'(match_count), 1);
        ts_ready = 1'b1; tick();
        check("first_pop", 32'(ts_valid), 0);
        tick();  // ready while empty does nothing
        check("ready_empty_valid", 32'(ts_valid), 0);
        check("ready_empty_match", 32'(match_count), 1);
        ts_ready = 1'b0;

        // Single match at ts 5
        while (ts < 5) tick();
        z = 1'b1; tick(); z = 1'b0;
        check("single_valid", 32'(ts_valid), 1);
        check("single_data", 32'(ts_data), 5);
        check("single_match", 32'(match_count), 2);
        tick();
        check("single_hold", 32'(ts_data), 5);
        ts_ready = 1'b1; tick(); ts_ready = 1'b0;
        check("single_pop", 32'(ts_valid), 0);

        // Overflow: six matches at 10..20 step 2, no reads
        while (ts < 10) tick();
        for (int i = 0; i < 6; i++) begin
            z = 1'b1; tick(); z = 1'b0; tick();
        end
        check("ovf_drop", 32'(drop_count), 2);
        check("ovf_flag", 32'(overflow), 1);
        check("ovf_match", 32'(match_count), 8);
        for (int k = 0; k < 4; k++) begin
            check("ovf_rd_valid", 32'(ts_valid), 1);
            check("ovf_rd_data", 32'(ts_data), 32'(10 + 2 * k));
            ts_ready = 1'b1; tick();
        end
        ts_ready = 1'b0;
        check("ovf_empty", 32'(ts_valid), 0);

        // Fill with consecutive matches, then push and pop on one edge
        a = ts;
        z = 1'b1; repeat (4) tick();
        check("full_nodrop", 32'(drop_count), 2);
        check("full_head", 32'(ts_data), 32'(a));
        b = ts;
        ts_ready = 1'b1; tick(); z = 1'b0;
        check("pp_drop", 32'(drop_count), 2);
        check("pp_ovf", 32'(overflow), 1);
        check("pp_match", 32'(match_count), 13);
        for (int k = 0; k < 4; k++) begin
            check("pp_rd_data", 32'(ts_data), (k < 3) ? 32'(a + 1 + k) : 32'(b));
            tick();
        end
        ts_ready = 1'b0;
        check("pp_empty", 32'(ts_valid), 0);

        // Empty with push and ready together: push only
        c = ts;
        z = 1'b1; ts_ready = 1'b1; tick(); z = 1'b0; ts_ready = 1'b0;
        check("ep_valid", 32'(ts_valid), 1);
        check("ep_data", 32'(ts_data), 32'(c));
        check("ep_match", 32'(match_count), 14);
        ts_ready = 1'b1; tick(); ts_ready = 1'b0;
        check("ep_pop", 32'(ts_valid), 0);

        // Narrow instance: timestamp wrap and count saturation
        while ((ts % 16) != 15) tick();
        z2 = 1'b1; repeat (5) tick(); z2 = 1'b0;
        check("sat_match", 32'(match_count2), 3);
        check("sat_drop", 32'(drop_count2), 1);
        check("sat_ovf", 32'(overflow2), 1);
        for (int k = 0; k < 4; k++) begin
            check("wrap_rd_data", 32'(ts_data2), (k == 0) ? 32'd15 : 32'(k - 1));
            ts_ready2 = 1'b1; tick();
        end
        ts_ready2 = 1'b0;
        check("wrap_empty", 32'(ts_valid2), 0);
        z2 = 1'b1; tick(); z2 = 1'b0;
        check("sat_hold", 32'(match_count2), 3);
        check("sat_new_data", 32'(ts_data2), 32'((ts - 1) % 16));

        // Asynchronous reset with three entries queued
        z = 1'b1; repeat (3) tick(); z = 1'b0;
        check("pre_rst_valid", 32'(ts_valid), 1);
        check("pre_rst_match", 32'(match_count), 17);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(ts_valid), 0);
        check("arst_data", 32'(ts_data), 0);
        check("arst_match", 32'(match_count), 0);
        check("arst_drop", 32'(drop_count), 0);
        check("arst_ovf", 32'(overflow), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        ts = 0;
        tick();
        check("no_replay", 32'(ts_valid), 0);

`ifdef MATCH_LOG_CLEAR_EN
        // Synchronous clear wins over a simultaneous push and pop
        z = 1'b1; repeat (2) tick(); z = 1'b0;
        check("pre_clr_valid", 32'(ts_valid), 1);
        z = 1'b1; clr = 1'b1; ts_ready = 1'b1; tick();
        z = 1'b0; clr = 1'b0; ts_ready = 1'b0;
        ts = 0;
        check("clr_valid", 32'(ts_valid), 0);
        check("clr_match", 32'(match_count), 0);
        check("clr_drop", 32'(drop_count), 0);
        check("clr_ovf", 32'(overflow), 0);
        z = 1'b1; tick(); z = 1'b0;
        check("clr_ts_zero", 32'(ts_data), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
